sobel_frame_ctrl: RTL and testbench
===================================

Name: sobel_frame_ctrl

Overview:
Frame-level sequencer for the 3-line Sobel datapath. It streams an image row by row from image memory into the three line buffers, with zero rows for top and bottom padding. It triggers the Sobel row core once per output row and waits for the core's done. It sits between the image RAM, the line-buffer bank (ln0/ln1/ln2) and the per-row Sobel core.

Parameters:
IMG_W, 512, pixels per row (>= 2)
IMG_H, 512, rows per frame (>= 2)
COL_W, 9, column counter width, covers 0..IMG_W-1
ROW_W, 10, row counter width, covers 0..IMG_H+1
ADDR_W, 18, image memory address width, covers IMG_W*IMG_H-1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_start  in  1  start one frame; sampled only in IDLE
busy  out  1  high from the cycle after frame_start is accepted through DONE
frame_done  out  1  one-cycle pulse in DONE
mem_rd_en  out  1  image RAM read strobe; RAM has fixed 1-cycle read latency
mem_rd_addr  out  ADDR_W  src_row*IMG_W + col
lb_shift  out  1  rotate buffers: ln0<=ln1, ln1<=ln2
lb_wr_en  out  1  write one pixel into ln2
lb_wr_col  out  COL_W  ln2 column being written
lb_wr_zero  out  1  with lb_wr_en: write 0 instead of RAM data
core_start  out  1  one-cycle pulse: process the current buffer contents
core_row  out  ROW_W  output row index for the core; valid while core_start=1
core_done  in  1  core finished the row; sampled only in WAIT

Behaviour:
- Reset: state IDLE; every output and counter is 0.
- Fill pass k runs for k = 0..IMG_H+1 and loads source row k-1.
  - k=0 and k=IMG_H+1 are padding passes: zero writes, no RAM reads.
- States:
  - IDLE: on frame_start go to SHIFT with k=0.
  - SHIFT: 1 cycle, lb_shift=1, col=0; then FILL.
  - FILL: IMG_W cycles, col 0..IMG_W-1, one column per cycle.
    - Real row: mem_rd_en=1, mem_rd_addr=(k-1)*IMG_W+col.
    - Padding row: mem_rd_en=0.
    - After col IMG_W-1 go to DRAIN.
  - DRAIN: 1 cycle for the last delayed write.
    - If k>=2 go to START; else go to SHIFT with k+1.
  - START: 1 cycle, core_start=1, core_row=k-2; then WAIT.
  - WAIT: hold until core_done=1.
    - If k==IMG_H+1 go to DONE; else go to SHIFT with k+1.
  - DONE: 1 cycle, frame_done=1; then IDLE.
- Write pipeline:
  - lb_wr_en, lb_wr_col and lb_wr_zero are the FILL-cycle values registered one cycle.
  - Writes therefore appear on FILL cycles 2..IMG_W plus the DRAIN cycle.
  - lb_wr_zero=1 exactly for padding passes.
- Buffer contents when core_start=1 for row r: ln0=row r-1, ln1=row r, ln2=row r+1 (out-of-range rows are zero).
- Per-frame counts: IMG_H*IMG_W reads, (IMG_H+2)*IMG_W writes, IMG_H+2 shifts, IMG_H core starts.
- Busy cycles per frame: (IMG_H+2)*(IMG_W+2) + IMG_H*(1+d) + 1, where d is the number of WAIT cycles per row.
- Ignored inputs:
  - frame_start while busy.
  - core_done outside WAIT, including in START.
- Simultaneous events:
  - core_done and frame_start in the same WAIT cycle: only core_done acts.
  - A new frame needs frame_start again after DONE; back-to-back frame_start in the DONE cycle is ignored.
- Reset mid-frame: return to IDLE immediately; outputs go to 0; a partially filled ln2 is undefined and is refilled by the next frame.
- Arithmetic: counters are unsigned with no wrap inside a frame. The address is computed from row and column counters, not accumulated.

Optional Feature:
SOBEL_CTRL_STATS_EN
- Defined:
  - Adds output frame_cycles [31:0]: count of busy=1 cycles of the last completed frame.
  - Updated in the DONE cycle, with DONE itself included.
  - Held until the next DONE; 0 after reset; saturates at 2^32-1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=3, core_done 2 cycles after core_start (d=2), one frame_start -> 12 mem_rd_en, 20 lb_wr_en, 5 lb_shift, 3 core_start with core_row 0,1,2; busy for 40 cycles; one frame_done.
- Same setup, check addresses and writes -> mem_rd_addr sequence 0..11 in order; lb_wr_zero=1 on the first 4 and last 4 writes only; lb_wr_col follows mem_rd_en's column by exactly 1 cycle.
- Buffer model scoreboard, IMG_W=8, IMG_H=4, random image -> at each core_start, ln0/ln1/ln2 equal rows r-1/r/r+1, zero-padded at r=0 and r=3.
- core_done pulsed in START, in FILL, and 50 cycles late; frame_start pulsed mid-frame -> early and stray pulses ignored, controller waits for the WAIT-state pulse; no second frame starts.
- reset asserted during FILL of pass 2 -> next cycle all outputs 0, busy=0; a subsequent frame_start produces a complete, correct frame.
- SOBEL_CTRL_STATS_EN defined, d=2, IMG_W=4, IMG_H=3 -> frame_cycles=40 after DONE, 0 before the first frame.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame-level sequencer for the 3-line Sobel datapath.
//
// Streams an image row by row from the image RAM into the line-buffer bank
// (ln0/ln1/ln2), with zero rows at the top and bottom for padding. Once the
// three lines around an output row are loaded, it starts the per-row Sobel
// core and waits for its done.
//
// Fill pass k (0..IMG_H+1) loads source row k-1 into ln2. Passes 0 and
// IMG_H+1 are padding passes: they write zeros and do not read the RAM.
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   frame_start    start one frame (only looked at while idle)
//   busy           high from the cycle after frame_start is accepted up to
//                  and including the frame_done cycle
//   frame_done     one-cycle end-of-frame pulse
//   mem_rd_en      image RAM read strobe (RAM returns data one cycle later)
//   mem_rd_addr    src_row*IMG_W + col
//   lb_shift       rotate line buffers: ln0<=ln1, ln1<=ln2
//   lb_wr_en       write one pixel into ln2 at lb_wr_col
//   lb_wr_zero     with lb_wr_en: write 0 instead of RAM data
//   core_start     one-cycle pulse: run the core on the current buffers
//   core_row       output row index, valid with core_start
//   core_done      core finished its row (only looked at while waiting)
//   frame_cycles   (SOBEL_CTRL_STATS_EN only) busy cycles of the last
//                  completed frame, saturating
//
// Optional feature macro: SOBEL_CTRL_STATS_EN adds the frame_cycles port.

module sobel_frame_ctrl #(
    parameter int unsigned IMG_W  = 512,
    parameter int unsigned IMG_H  = 512,
    parameter int unsigned COL_W  = 9,
    parameter int unsigned ROW_W  = 10,
    parameter int unsigned ADDR_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              lb_shift,
    output logic              lb_wr_en,
    output logic [COL_W-1:0]  lb_wr_col,
    output logic              lb_wr_zero,
    output logic              core_start,
    output logic [ROW_W-1:0]  core_row,
    input  logic              core_done
`ifdef SOBEL_CTRL_STATS_EN
    ,
    output logic [31:0]       frame_cycles
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StFill,
        StDrain,
        StStart,
        StWait,
        StDone
    } state_e;

    localparam logic [COL_W-1:0] ColLast  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] PassLast = ROW_W'(IMG_H + 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] pass_q, pass_d;
    logic [COL_W-1:0] col_q, col_d;

    // Write pipeline: RAM data for a column arrives one cycle after its read,
    // so the ln2 write strobe/column trail the FILL column by one cycle.
    logic             wr_en_q;
    logic [COL_W-1:0] wr_col_q;
    logic             wr_zero_q;

    logic             real_row;
    logic [ROW_W-1:0] src_row;

    assign real_row = (pass_q != '0) && (pass_q != PassLast);
    assign src_row  = pass_q - ROW_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            pass_q    <= '0;
            col_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_col_q  <= '0;
            wr_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            col_q     <= col_d;
            wr_en_q   <= (state_q == StFill);
            wr_col_q  <= (state_q == StFill) ? col_q : '0;
            wr_zero_q <= (state_q == StFill) && !real_row;
        end
    end

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        col_d       = col_q;
        busy        = (state_q != StIdle);
        frame_done  = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        lb_shift    = 1'b0;
        core_start  = 1'b0;
        core_row    = '0;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StShift;
                    pass_d  = '0;
                    col_d   = '0;
                end
            end
            StShift: begin
                lb_shift = 1'b1;
                col_d    = '0;
                state_d  = StFill;
            end
            StFill: begin
                mem_rd_en = real_row;
                // Address is rebuilt from row/column every cycle, never accumulated.
                if (real_row) begin
                    mem_rd_addr = ADDR_W'(src_row) * ADDR_W'(IMG_W) + ADDR_W'(col_q);
                end
                if (col_q == ColLast) begin
                    col_d   = '0;
                    state_d = StDrain;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            StDrain: begin
                // From pass 2 on, ln0..ln2 hold the three rows around pass-2.
                if (pass_q >= ROW_W'(2)) begin
                    state_d = StStart;
                end else begin
                    pass_d  = pass_q + ROW_W'(1);
                    state_d = StShift;
                end
            end
            StStart: begin
                core_start = 1'b1;
                core_row   = pass_q - ROW_W'(2);
                state_d    = StWait;
            end
            StWait: begin
                if (core_done) begin
                    if (pass_q == PassLast) begin
                        state_d = StDone;
                    end else begin
                        pass_d  = pass_q + ROW_W'(1);
                        state_d = StShift;
                    end
                end
            end
            StDone: begin
                frame_done = 1'b1;
                pass_d     = '0;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign lb_wr_en   = wr_en_q;
    assign lb_wr_col  = wr_col_q;
    assign lb_wr_zero = wr_zero_q;

`ifdef SOBEL_CTRL_STATS_EN
    // run_cnt_q counts busy cycles before DONE; DONE adds its own cycle.
    logic [31:0] run_cnt_q;
    logic [31:0] frame_cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt_q      <= '0;
            frame_cycles_q <= '0;
        end else if (state_q == StDone) begin
            frame_cycles_q <= (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;
            run_cnt_q      <= '0;
        end else if (busy && (run_cnt_q != '1)) begin
            run_cnt_q <= run_cnt_q + 32'd1;
        end
    end

    assign frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Testbench for sobel_frame_ctrl (IMG_W=4, IMG_H=3).
// A frame-level model expands each accepted frame into its expected
// per-cycle output trace (WAIT phases end on the observed core_done) and a
// line-buffer model checks ln0/ln1/ln2 against the image at every core_start.

module tb_sobel_frame_ctrl;

    localparam int W      = 4;
    localparam int H      = 3;
    localparam int COL_W  = 2;
    localparam int ROW_W  = 3;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              reset;
    logic              frame_start;
    logic              busy;
    logic              frame_done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              lb_shift;
    logic              lb_wr_en;
    logic [COL_W-1:0]  lb_wr_col;
    logic              lb_wr_zero;
    logic              core_start;
    logic [ROW_W-1:0]  core_row;
    logic              core_done;
`ifdef SOBEL_CTRL_STATS_EN
    logic [31:0]       frame_cycles;
`endif

    sobel_frame_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .busy       (busy),
        .frame_done (frame_done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .lb_shift   (lb_shift),
        .lb_wr_en   (lb_wr_en),
        .lb_wr_col  (lb_wr_col),
        .lb_wr_zero (lb_wr_zero),
        .core_start (core_start),
        .core_row   (core_row),
        .core_done  (core_done)
`ifdef SOBEL_CTRL_STATS_EN
        ,
        .frame_cycles(frame_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- image RAM (1-cycle read latency) ----------------
    logic [7:0] img [W*H];
    logic [7:0] ram_data;

    always @(posedge clk) begin
        if (mem_rd_en) ram_data <= img[int'(mem_rd_addr)];
    end

    task automatic fill_img();
        for (int i = 0; i < W * H; i++) img[i] = 8'($urandom_range(1, 255));
    endtask

    function automatic logic [7:0] pix(input int row, input int col);
        if (row < 0 || row >= H) return 8'd0;
        return img[row * W + col];
    endfunction

    // ---------------- core responder ----------------
    int resp_delay  = 2;
    bit stray_start = 0;
    bit stray_fill  = 0;

    initial begin
        int cnt;
        bit pend;
        bit fill_done;
        core_done = 1'b0;
        pend      = 0;
        fill_done = 0;
        cnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (reset) begin
                pend = 0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    pend      = 0;
                end
            end else if (core_start) begin
                pend = 1;
                cnt  = resp_delay;
                if (stray_start) core_done = 1'b1;
            end
            if (!reset && stray_fill && !fill_done && mem_rd_en && !core_done) begin
                core_done = 1'b1;
                fill_done = 1;
            end
        end
    end

    // ---------------- frame model ----------------
    typedef struct packed {
        logic              wait_m;
        logic              busy;
        logic              shift;
        logic              rd_en;
        logic [ADDR_W-1:0] addr;
        logic              wr_en;
        logic [COL_W-1:0]  wr_col;
        logic              wr_zero;
        logic              cstart;
        logic [ROW_W-1:0]  crow;
        logic              fdone;
    } rec_t;

    rec_t exp_q [$];

    function automatic rec_t mask(input rec_t x);
        rec_t y = x;
        y.wait_m = 1'b0;
        if (!y.rd_en) y.addr = '0;
        if (!y.wr_en) begin
            y.wr_col  = '0;
            y.wr_zero = 1'b0;
        end
        if (!y.cstart) y.crow = '0;
        return y;
    endfunction

    // Expected trace of one frame, starting the cycle after acceptance.
    task automatic build_frame();
        rec_t r;
        for (int k = 0; k <= H + 1; k++) begin
            bit real_row = (k >= 1) && (k <= H);
            r = '0; r.busy = 1'b1; r.shift = 1'b1;
            exp_q.push_back(r);
            for (int c = 0; c <= W; c++) begin    // c == W is the drain cycle
                r = '0; r.busy = 1'b1;
                if (c < W && real_row) begin
                    r.rd_en = 1'b1;
                    r.addr  = ADDR_W'((k - 1) * W + c);
                end
                if (c > 0) begin
                    r.wr_en   = 1'b1;
                    r.wr_col  = COL_W'(c - 1);
                    r.wr_zero = !real_row;
                end
                exp_q.push_back(r);
            end
            if (k >= 2) begin
                r = '0; r.busy = 1'b1; r.cstart = 1'b1; r.crow = ROW_W'(k - 2);
                exp_q.push_back(r);
                r = '0; r.busy = 1'b1; r.wait_m = 1'b1;
                exp_q.push_back(r);
            end
        end
        r = '0; r.busy = 1'b1; r.fdone = 1'b1;
        exp_q.push_back(r);
    endtask

    // Line-buffer model driven by the DUT's shift/write strobes.
    logic [7:0] ln0 [W];
    logic [7:0] ln1 [W];
    logic [7:0] ln2 [W];

    task automatic check_lines(input int r);
        logic [63:0] a, e;
        for (int l = 0; l < 3; l++) begin
            a = '0;
            e = '0;
            for (int c = 0; c < W; c++) begin
                e[8*c +: 8] = pix(r - 1 + l, c);
                a[8*c +: 8] = (l == 0) ? ln0[c] : (l == 1) ? ln1[c] : ln2[c];
            end
            chk($sformatf("ln%0d_at_row%0d", l, r), a, e);
        end
    endtask

    // Per-frame tallies, checked against hand-computed totals at frame_done.
    int n_rd, n_wr, n_shift, n_cs, n_busy, n_frames = 0;
    int exp_busy = 40;
    int addr_q [$];
    int zero_q [$];
    int row_q  [$];

    task automatic clear_tallies();
        n_rd = 0; n_wr = 0; n_shift = 0; n_cs = 0; n_busy = 0;
        addr_q.delete();
        zero_q.delete();
        row_q.delete();
    endtask

    task automatic frame_checks();
        chk("rd_count", 64'(n_rd), 64'd12);
        chk("wr_count", 64'(n_wr), 64'd20);
        chk("shift_count", 64'(n_shift), 64'd5);
        chk("core_start_count", 64'(n_cs), 64'd3);
        chk("busy_cycles", 64'(n_busy), 64'(exp_busy));
        foreach (addr_q[i]) chk($sformatf("rd_addr[%0d]", i), 64'(addr_q[i]), 64'(i));
        foreach (zero_q[i]) chk($sformatf("wr_zero[%0d]", i), 64'(zero_q[i]),
                                64'((i < 4) || (i >= 16)));
        foreach (row_q[i]) chk($sformatf("core_row[%0d]", i), 64'(row_q[i]), 64'(i));
    endtask

    initial clear_tallies();

    always @(negedge clk) begin
        rec_t act, e;
        act = '0;
        act.busy    = busy;
        act.shift   = lb_shift;
        act.rd_en   = mem_rd_en;
        act.addr    = mem_rd_addr;
        act.wr_en   = lb_wr_en;
        act.wr_col  = lb_wr_col;
        act.wr_zero = lb_wr_zero;
        act.cstart  = core_start;
        act.crow    = core_row;
        act.fdone   = frame_done;
        if (reset) begin
            chk("reset_outputs", 64'(act), 64'd0);
            exp_q.delete();
            clear_tallies();
        end else begin
            if (exp_q.size() == 0) begin
                chk("idle_outputs", 64'(mask(act)), 64'd0);
                if (frame_start) build_frame();
            end else begin
                e = exp_q[0];
                chk(e.wait_m ? "wait_outputs" : "frame_trace", 64'(mask(act)), 64'(mask(e)));
                if (!e.wait_m || core_done) void'(exp_q.pop_front());
            end
            if (act.busy) n_busy++;
            if (act.shift) begin
                n_shift++;
                ln0 = ln1;
                ln1 = ln2;
            end
            if (act.rd_en) begin
                n_rd++;
                addr_q.push_back(int'(act.addr));
            end
            if (act.wr_en) begin
                n_wr++;
                zero_q.push_back(int'(act.wr_zero));
                ln2[act.wr_col] = act.wr_zero ? 8'd0 : ram_data;
            end
            if (act.cstart) begin
                n_cs++;
                row_q.push_back(int'(act.crow));
                check_lines(int'(act.crow));
            end
            if (act.fdone) begin
                frame_checks();
                n_frames++;
                clear_tallies();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!frame_done && n < limit) begin
            tick();
            n++;
        end
        chk("frame_done_seen", 64'(frame_done), 64'd1);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        frame_start = 1'b0;
        fill_img();
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'd0);
`ifdef SOBEL_CTRL_STATS_EN
        chk("stats_after_reset", 64'(frame_cycles), 64'd0);
`endif
        reset = 1'b0;
        repeat (2) tick();

        // Frame 1: plain frame, core answers after 2 WAIT cycles.
        exp_busy    = 40;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_done(2000);
        tick();
`ifdef SOBEL_CTRL_STATS_EN
        chk("stats_frame1", 64'(frame_cycles), 64'd40);
`endif
        repeat (3) tick();

        // Frame 2: late core_done, stray core_done in START and FILL, frame_start noise.
        fill_img();
        resp_delay  = 50;
        stray_start = 1;
        stray_fill  = 1;
        exp_busy    = 30 + 3 * 51 + 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (10) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!core_start && n < 200) begin
            tick();
            n++;
        end
        chk("core_start_seen", 64'(core_start), 64'd1);
        frame_start = 1'b1;              // held across the WAIT's core_done cycle
        repeat (60) tick();
        frame_start = 1'b0;
        wait_done(2000);
        frame_start = 1'b1;              // in the DONE cycle: must be ignored
        tick();
        frame_start = 1'b0;
`ifdef SOBEL_CTRL_STATS_EN
        chk("stats_frame2", 64'(frame_cycles), 64'd184);
`endif
        repeat (5) tick();
        chk("no_second_frame", 64'(busy), 64'd0);

        // Frame 3: reset during FILL of pass 2.
        resp_delay  = 2;
        stray_start = 0;
        stray_fill  = 0;
        exp_busy    = 40;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!(mem_rd_en && mem_rd_addr == ADDR_W'(4)) && n < 200) begin
            tick();
            n++;
        end
        chk("pass2_fill_seen", 64'(mem_rd_en), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_busy", 64'(busy), 64'd0);
        tick();
        chk("reset_all_outputs",
            64'({busy, frame_done, mem_rd_en, mem_rd_addr, lb_shift, lb_wr_en,
                 lb_wr_col, lb_wr_zero, core_start, core_row}), 64'd0);
`ifdef SOBEL_CTRL_STATS_EN
        chk("stats_mid_reset", 64'(frame_cycles), 64'd0);
`endif
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Frame 4: complete frame after the aborted one.
        fill_img();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_done(2000);
        tick();
`ifdef SOBEL_CTRL_STATS_EN
        chk("stats_frame4", 64'(frame_cycles), 64'd40);
`endif
        repeat (3) tick();
        chk("frames_completed", 64'(n_frames), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
